// File: rtl/tl_ad_buffer_pkg.sv
// Bundle package for the TileLink A/D buffer: channel beat structs, opcode
// encodings and a helper that sizes occupancy counters.
package tl_ad_buffer_pkg;

  // A-channel beat (client -> manager)
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [3:0]  source;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } TLBundleAST;

  // D-channel beat (manager -> client)
  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [3:0]  size;
    logic [3:0]  source;
    logic [3:0]  sink;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } TLBundleDST;

  // Opcode encodings
  localparam logic [2:0] TL_A_PUT_FULL_DATA   = 3'd0;
  localparam logic [2:0] TL_A_GET             = 3'd4;
  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  // Occupancy counter width; a wire-through queue still gets a 1-bit port.
  function automatic int count_width(input int depth);
    return (depth <= 0) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tl_ad_buffer_queue.sv
// Generic ready/valid queue (tl_queue) carrying whole beats of type T.
// DEPTH 0 is a plain wire; otherwise circular storage with a maybe_full flag.
// PIPE lets a full queue accept while dequeuing; FLOW bypasses an empty queue.
module tl_queue
  import tl_ad_buffer_pkg::*;
#(
  parameter type T      = logic,
  parameter int  DEPTH  = 2,
  parameter int  PIPE   = 0,
  parameter int  FLOW   = 0,
  localparam int CW     = count_width(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  T              in_bits,
  output logic          out_valid,
  input  logic          out_ready,
  output T              out_bits,
  output logic [CW-1:0] count
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign out_valid = in_valid;
      assign out_bits  = in_bits;
      assign in_ready  = out_ready;
      assign count     = '0;
      logic w_unused;
      assign w_unused = ^{clock, reset_n};
    end else begin : g_fifo
      localparam int PW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);

      T              r_mem [DEPTH];
      logic [PW-1:0] r_enq_ptr;
      logic [PW-1:0] r_deq_ptr;
      logic          r_maybe_full;
      logic [CW-1:0] r_count;
      logic          w_ptr_match;
      logic          w_empty;
      logic          w_full;
      logic          w_do_enq;
      logic          w_do_deq;
      logic [PW-1:0] w_enq_ptr_next;
      logic [PW-1:0] w_deq_ptr_next;

      assign w_ptr_match    = (r_enq_ptr == r_deq_ptr);
      assign w_empty        = w_ptr_match && !r_maybe_full;
      assign w_full         = w_ptr_match && r_maybe_full;
      assign w_enq_ptr_next = (r_enq_ptr == PW'(DEPTH - 1)) ? '0 : r_enq_ptr + 1'b1;
      assign w_deq_ptr_next = (r_deq_ptr == PW'(DEPTH - 1)) ? '0 : r_deq_ptr + 1'b1;
      assign count          = r_count;

      // Handshake and bypass: a flowing empty queue hands the input straight out
      always_comb begin
        out_valid = !w_empty;
        out_bits  = r_mem[r_deq_ptr];
        in_ready  = !w_full || ((PIPE != 0) && out_ready);
        w_do_enq  = in_valid && in_ready;
        w_do_deq  = out_valid && out_ready;
        if ((FLOW != 0) && w_empty) begin
          out_valid = in_valid;
          out_bits  = in_bits;
          w_do_deq  = 1'b0;
          if (out_ready) begin
            w_do_enq = 1'b0;
          end
        end
      end

      // Entry storage: written on enqueue, never reset
      always_ff @(posedge clock) begin
        if (w_do_enq) begin
          r_mem[r_enq_ptr] <= in_bits;
        end
      end

      // Pointers, fullness flag and occupancy
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_enq_ptr    <= '0;
          r_deq_ptr    <= '0;
          r_maybe_full <= 1'b0;
          r_count      <= '0;
        end else begin
          if (w_do_enq) begin
            r_enq_ptr <= w_enq_ptr_next;
          end
          if (w_do_deq) begin
            r_deq_ptr <= w_deq_ptr_next;
          end
          if (w_do_enq != w_do_deq) begin
            r_maybe_full <= w_do_enq;
            r_count      <= w_do_enq ? r_count + 1'b1 : r_count - 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/tl_ad_buffer.sv
// TileLink A/D channel buffer: one independent queue per channel between the
// L1 client port and the manager port.
// Optional macro TL_AD_BUFFER_PERF_EN adds saturating 16-bit stall counters.
module tl_ad_buffer
  import tl_ad_buffer_pkg::*;
#(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2,
  parameter int A_PIPE  = 0,
  parameter int D_PIPE  = 0,
  parameter int A_FLOW  = 0,
  parameter int D_FLOW  = 0
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              a_in_valid,
  output logic                              a_in_ready,
  input  TLBundleAST                        a_in_bits,
  output logic                              a_out_valid,
  input  logic                              a_out_ready,
  output TLBundleAST                        a_out_bits,
  input  logic                              d_in_valid,
  output logic                              d_in_ready,
  input  TLBundleDST                        d_in_bits,
  output logic                              d_out_valid,
  input  logic                              d_out_ready,
  output TLBundleDST                        d_out_bits,
  output logic [count_width(A_DEPTH)-1:0]   a_count,
  output logic [count_width(D_DEPTH)-1:0]   d_count
`ifdef TL_AD_BUFFER_PERF_EN
  ,
  output logic [15:0]                       a_stall_cycles,
  output logic [15:0]                       d_stall_cycles
`else
`endif
);

  tl_queue #(
    .T     (TLBundleAST),
    .DEPTH (A_DEPTH),
    .PIPE  (A_PIPE),
    .FLOW  (A_FLOW)
  ) u_a_queue (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_bits   (a_in_bits),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_bits  (a_out_bits),
    .count     (a_count)
  );

  tl_queue #(
    .T     (TLBundleDST),
    .DEPTH (D_DEPTH),
    .PIPE  (D_PIPE),
    .FLOW  (D_FLOW)
  ) u_d_queue (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .in_bits   (d_in_bits),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .out_bits  (d_out_bits),
    .count     (d_count)
  );

`ifdef TL_AD_BUFFER_PERF_EN
  logic [15:0] r_a_stall;
  logic [15:0] r_d_stall;

  // Count cycles where a beat is offered but not taken, saturating at all-ones
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a_stall <= '0;
      r_d_stall <= '0;
    end else begin
      if (a_out_valid && !a_out_ready && (r_a_stall != 16'hFFFF)) begin
        r_a_stall <= r_a_stall + 16'd1;
      end
      if (d_out_valid && !d_out_ready && (r_d_stall != 16'hFFFF)) begin
        r_d_stall <= r_d_stall + 16'd1;
      end
    end
  end

  assign a_stall_cycles = r_a_stall;
  assign d_stall_cycles = r_d_stall;
`else
`endif

endmodule
